mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Cache-to-RAM controller. Shares the single-word RAM port between the icache and dcache of every CPU.
- Sits behind the caches on the cc side of the cache/controller interface, with one RAM port below it.
- Sequences each RAM transaction through an FSM, arbitrates round-robin across CPUs, and returns wait/load to the granted cache.
- Optionally sequences snoop/invalidate broadcasts ahead of coherent dcache transactions.

Parameters:
- CPUS, 1: number of CPUs; each has one icache and one dcache requester.
- WORD_W, 32: word width (word_t).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- iREN  input  CPUS  icache read request, per CPU.
- dREN  input  CPUS  dcache read request.
- dWEN  input  CPUS  dcache write request.
- iaddr  input  CPUS*WORD_W  icache address.
- daddr  input  CPUS*WORD_W  dcache address.
- dstore  input  CPUS*WORD_W  dcache write data.
- iwait  output  CPUS  icache must stall.
- dwait  output  CPUS  dcache must stall.
- iload  output  CPUS*WORD_W  instruction read data.
- dload  output  CPUS*WORD_W  data read data.
- ccwrite  input  CPUS  dcache transaction is a write intent (I/S->M).
- cctrans  input  CPUS  dcache is changing coherence state.
- ccwait  output  CPUS  block this CPU for a snoop.
- ccinv  output  CPUS  invalidate the snooped entry.
- ccsnoopaddr  output  CPUS*WORD_W  address being snooped.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.

Behaviour:
- Reset: RST high at a rising edge gives state=IDLE and rr_ptr=0. All iwait/dwait=1. ramREN=ramWEN=0. ramaddr/ramstore/iload/dload=0. ccwait/ccinv=0, ccsnoopaddr=0.
- Reset mid-access abandons the transaction immediately. No wait is dropped.
- Requester slots, searched from rr_ptr upward, wrapping modulo CPUS:
  - Per CPU, dcache (dWEN|dREN) beats icache (iREN).
  - dWEN beats dREN if both are high.
- IDLE: if any request, latch grant (cpu index, I/D, read/write) and go to ACCESS, or SNOOP when the optional feature applies. ram enables stay 0 in IDLE.
- ACCESS: drive ramaddr/ramstore from the latched requester. Assert ramREN or ramWEN, never both.
  - ramstate FREE/BUSY: hold all outputs.
  - ramstate ERROR: hold and retry; no wait released.
  - ramstate ACCESS: in the same cycle (combinational), deassert the granted iwait/dwait and drive its iload/dload = ramload. Next state IDLE. rr_ptr = (granted cpu + 1) mod CPUS.
- Grant is held until completion even if another CPU requests.
- If the granted request drops before ACCESS, return to IDLE with no wait pulse. ram enables drop the next cycle.
- Latency with zero-wait RAM: request at cycle 0, ram enable at cycle 1, wait low at cycle 1, next grant earliest at cycle 2. A single requester therefore gets at most 1 word per 2 cycles.
- Non-granted waits stay 1 throughout. iload/dload of non-granted slots hold their last value.
- Starvation bound: a continuously requesting CPU is served within CPUS grants.

Optional Feature:
- Macro: MEM_ARBITER_COHERENCE_EN.
- Defined:
  - A dcache grant with cctrans[k]=1 enters SNOOP for exactly 1 cycle before ACCESS.
  - From SNOOP through ACCESS completion, every j!=k gets ccwait[j]=1, ccsnoopaddr[j]=daddr[k], ccinv[j]=ccwrite[k].
  - All three clear in the cycle after completion.
  - An icache grant, or cctrans=0, skips SNOOP.
- Undefined: SNOOP never entered. ccwait/ccinv/ccsnoopaddr tied 0. ccwrite/cctrans ignored.

Test Plan:
- Reset held 3 cycles with iREN[0]=1 -> ramREN=0, iwait=1 throughout. After release: ramREN=1 at cycle 1, ramaddr=iaddr[0].
- CPUS=1, iREN=1 iaddr=0x40 and dWEN=1 daddr=0x80 dstore=0xDEADBEEF, RAM ACCESS every cycle -> write to 0x80 first (ramWEN=1, ramstore=0xDEADBEEF, dwait low), then read of 0x40 with iload=ramload.
- RAM BUSY 3 cycles then ACCESS, ramload=0x1234 -> dwait stays 1 for 3 cycles, falls on the ACCESS cycle with dload=0x1234. ramREN held 4 cycles.
- CPUS=2, both dREN continuously -> grants alternate CPU0, CPU1, CPU0. Neither CPU waits more than 2 grants.
- ramstate=ERROR for 2 cycles then ACCESS -> ram enable held throughout, wait released only at ACCESS.
- MEM_ARBITER_COHERENCE_EN, CPUS=2, CPU0 dWEN with cctrans=1, ccwrite=1, daddr=0x100 -> 1 SNOOP cycle with ram enables 0. ccwait[1]=ccinv[1]=1 and ccsnoopaddr[1]=0x100 through the write. All three clear the cycle after completion.

Source files
------------

// File: rtl/mem_arbiter.sv
// Cache-to-RAM controller: round-robin arbitration of per-CPU icache/dcache requests onto one RAM port.
// Optional snoop/invalidate sequencing ahead of coherent dcache grants when MEM_ARBITER_COHERENCE_EN is defined.
module mem_arbiter #(
    parameter int CPUS   = 1,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    input  logic [CPUS-1:0]          ccwrite,
    input  logic [CPUS-1:0]          cctrans,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore
);

    localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int SLOTS = 1 << PTR_W;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [PTR_W-1:0]     gnt_cpu_r;
    logic                 gnt_d_r;
    logic                 gnt_w_r;
    logic [WORD_W-1:0]    iload_r [SLOTS];
    logic [WORD_W-1:0]    dload_r [SLOTS];

    // Per-slot views; slots past CPUS are padded so any PTR_W index is in range.
    logic [SLOTS-1:0]     iren_s;
    logic [SLOTS-1:0]     dren_s;
    logic [SLOTS-1:0]     dwen_s;
    logic [WORD_W-1:0]    iaddr_s  [SLOTS];
    logic [WORD_W-1:0]    daddr_s  [SLOTS];
    logic [WORD_W-1:0]    dstore_s [SLOTS];

    logic                 found_s;
    logic [PTR_W-1:0]     pick_cpu_s;
    logic                 pick_d_s;
    logic                 pick_w_s;
    logic                 coh_pick_s;
    int                   idx_s;
    logic                 gnt_req_s;
    logic                 ram_ok_s;
    logic                 done_s;

    genvar g;
    for (g = 0; g < SLOTS; g++) begin : g_unpack
        if (g < CPUS) begin : g_real
            assign iren_s[g]   = iREN[g];
            assign dren_s[g]   = dREN[g];
            assign dwen_s[g]   = dWEN[g];
            assign iaddr_s[g]  = iaddr[g*WORD_W +: WORD_W];
            assign daddr_s[g]  = daddr[g*WORD_W +: WORD_W];
            assign dstore_s[g] = dstore[g*WORD_W +: WORD_W];
        end else begin : g_pad
            assign iren_s[g]   = 1'b0;
            assign dren_s[g]   = 1'b0;
            assign dwen_s[g]   = 1'b0;
            assign iaddr_s[g]  = '0;
            assign daddr_s[g]  = '0;
            assign dstore_s[g] = '0;
        end
    end

`ifdef MEM_ARBITER_COHERENCE_EN
    logic [SLOTS-1:0]     cctrans_s;
    logic [SLOTS-1:0]     ccwrite_s;
    logic                 gnt_coh_r;
    for (g = 0; g < SLOTS; g++) begin : g_cc_unpack
        if (g < CPUS) begin : g_real
            assign cctrans_s[g] = cctrans[g];
            assign ccwrite_s[g] = ccwrite[g];
        end else begin : g_pad
            assign cctrans_s[g] = 1'b0;
            assign ccwrite_s[g] = 1'b0;
        end
    end
    assign coh_pick_s = pick_d_s & cctrans_s[pick_cpu_s];
`else
    logic unused_cc_s;
    assign unused_cc_s = ^{ccwrite, cctrans};
    assign coh_pick_s  = 1'b0;
`endif

    // Round-robin search from rr_ptr; dcache beats icache, write beats read.
    always_comb begin
        found_s    = 1'b0;
        pick_cpu_s = '0;
        pick_d_s   = 1'b0;
        pick_w_s   = 1'b0;
        idx_s      = 0;
        for (int i = 0; i < CPUS; i++) begin
            idx_s      = (int'(rr_ptr_r) + i >= CPUS) ? int'(rr_ptr_r) + i - CPUS : int'(rr_ptr_r) + i;
            pick_cpu_s = (!found_s && (dwen_s[idx_s] | dren_s[idx_s] | iren_s[idx_s])) ? PTR_W'(idx_s) : pick_cpu_s;
            pick_d_s   = (!found_s && (dwen_s[idx_s] | dren_s[idx_s] | iren_s[idx_s])) ? (dwen_s[idx_s] | dren_s[idx_s]) : pick_d_s;
            pick_w_s   = (!found_s && (dwen_s[idx_s] | dren_s[idx_s] | iren_s[idx_s])) ? dwen_s[idx_s] : pick_w_s;
            found_s    = found_s | dwen_s[idx_s] | dren_s[idx_s] | iren_s[idx_s];
        end
    end

    // Liveness of the latched request and RAM completion decode; ERROR simply retries.
    always_comb begin
        gnt_req_s = gnt_d_r ? (gnt_w_r ? dwen_s[gnt_cpu_r] : dren_s[gnt_cpu_r]) : iren_s[gnt_cpu_r];
        case (ramstate)
            RAM_ACCESS:                    ram_ok_s = 1'b1;
            RAM_FREE, RAM_BUSY, RAM_ERROR: ram_ok_s = 1'b0;
            default:                       ram_ok_s = 1'b0;
        endcase
        done_s = (state_r == ACCESS) && gnt_req_s && ram_ok_s;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a dropped request abandons the grant without a wait release.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = coh_pick_s ? SNOOP : ACCESS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SNOOP:   state_nx_s = gnt_req_s ? ACCESS : IDLE;
            ACCESS:  state_nx_s = (done_s || !gnt_req_s) ? IDLE : ACCESS;
            default: state_nx_s = IDLE;
        endcase
    end

    // Grant latch, round-robin pointer and per-slot read-data holding registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_r  <= '0;
            gnt_cpu_r <= '0;
            gnt_d_r   <= 1'b0;
            gnt_w_r   <= 1'b0;
`ifdef MEM_ARBITER_COHERENCE_EN
            gnt_coh_r <= 1'b0;
`endif
            for (int k = 0; k < SLOTS; k++) begin
                iload_r[k] <= '0;
                dload_r[k] <= '0;
            end
        end else begin
            if (state_r == IDLE && found_s) begin
                gnt_cpu_r <= pick_cpu_s;
                gnt_d_r   <= pick_d_s;
                gnt_w_r   <= pick_w_s;
`ifdef MEM_ARBITER_COHERENCE_EN
                gnt_coh_r <= coh_pick_s;
`endif
            end
            if (done_s) begin
                rr_ptr_r <= (gnt_cpu_r == PTR_W'(CPUS - 1)) ? '0 : gnt_cpu_r + PTR_W'(1);
                if (gnt_d_r) begin
                    dload_r[gnt_cpu_r] <= ramload;
                end else begin
                    iload_r[gnt_cpu_r] <= ramload;
                end
            end
        end
    end

    // Output decode: RAM port, waits/loads of the granted slot, snoop broadcast.
    always_comb begin
        ramREN      = (state_r == ACCESS) && !gnt_w_r;
        ramWEN      = (state_r == ACCESS) && gnt_w_r;
        ramaddr     = (state_r == ACCESS) ? (gnt_d_r ? daddr_s[gnt_cpu_r] : iaddr_s[gnt_cpu_r]) : '0;
        ramstore    = ((state_r == ACCESS) && gnt_w_r) ? dstore_s[gnt_cpu_r] : '0;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        for (int k = 0; k < CPUS; k++) begin
            iwait[k] = !(done_s && gnt_cpu_r == PTR_W'(k) && !gnt_d_r);
            dwait[k] = !(done_s && gnt_cpu_r == PTR_W'(k) && gnt_d_r);
            iload[k*WORD_W +: WORD_W] = (done_s && gnt_cpu_r == PTR_W'(k) && !gnt_d_r) ? ramload : iload_r[k];
            dload[k*WORD_W +: WORD_W] = (done_s && gnt_cpu_r == PTR_W'(k) && gnt_d_r) ? ramload : dload_r[k];
`ifdef MEM_ARBITER_COHERENCE_EN
            ccwait[k] = gnt_coh_r && (state_r == SNOOP || state_r == ACCESS) && (gnt_cpu_r != PTR_W'(k));
            ccinv[k]  = ccwait[k] && ccwrite_s[gnt_cpu_r];
            ccsnoopaddr[k*WORD_W +: WORD_W] = ccwait[k] ? daddr_s[gnt_cpu_r] : '0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two CPUs; coherence checks follow MEM_ARBITER_COHERENCE_EN.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait, ccwait, ccinv;
    logic [63:0] iload, dload, ccsnoopaddr;
    logic [31:0] ramload, ramaddr, ramstore;
    logic [1:0]  ramstate;
    logic        ramREN, ramWEN;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.CPUS(2), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramload(ramload), .ramstate(ramstate),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; iREN = 2'b01; dREN = 2'b00; dWEN = 2'b00;
        ccwrite = 2'b00; cctrans = 2'b00;
        iaddr = 64'h0000_0000_0000_0040; daddr = 64'd0; dstore = 64'd0;
        ramstate = 2'd2; ramload = 32'h55;

        // Reset held with a pending icache request
        tick();
        for (int r = 0; r < 3; r++) begin
            sample();
            chk("rst_ramren", {31'd0, ramREN}, 32'd0);
            chk("rst_iwait", {30'd0, iwait}, 32'd3);
            tick();
        end
        RST = 1'b0;
        sample();
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_dwait", {30'd0, dwait}, 32'd3);
        chk("rst_iload0", iload[31:0], 32'd0);
        chk("rst_ccwait", {30'd0, ccwait}, 32'd0);
        tick();
        sample();
        chk("first_ramren", {31'd0, ramREN}, 32'd1);
        chk("first_ramaddr", ramaddr, 32'h40);
        chk("first_iwait", {30'd0, iwait}, 32'd2);
        chk("first_iload0", iload[31:0], 32'h55);
        tick();
        iREN = 2'b00; ramload = 32'h66;
        sample();
        chk("first_idle_iwait", {30'd0, iwait}, 32'd3);
        chk("first_idle_ramren", {31'd0, ramREN}, 32'd0);
        chk("iload_hold", iload[31:0], 32'h55);

        // dcache write beats icache read on the same CPU
        iREN = 2'b01; dWEN = 2'b01; daddr = 64'h80; dstore = 64'hDEADBEEF; ramload = 32'h77;
        tick();
        sample();
        chk("wr_ramwen", {31'd0, ramWEN}, 32'd1);
        chk("wr_ramren", {31'd0, ramREN}, 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h80);
        chk("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_dwait", {30'd0, dwait}, 32'd2);
        chk("wr_iwait", {30'd0, iwait}, 32'd3);
        tick();
        dWEN = 2'b00;
        sample();
        chk("gap_ramwen", {31'd0, ramWEN}, 32'd0);
        chk("gap_iwait", {30'd0, iwait}, 32'd3);
        tick();
        sample();
        chk("rd_ramren", {31'd0, ramREN}, 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h40);
        chk("rd_iwait", {30'd0, iwait}, 32'd2);
        chk("rd_iload0", iload[31:0], 32'h77);
        tick();
        iREN = 2'b00;

        // RAM BUSY for three cycles then ACCESS
        dREN = 2'b01; daddr = 64'h200; ramstate = 2'd1; ramload = 32'h1234;
        tick();
        for (int b = 0; b < 3; b++) begin
            sample();
            chk("busy_ramren", {31'd0, ramREN}, 32'd1);
            chk("busy_dwait", {30'd0, dwait}, 32'd3);
            tick();
        end
        ramstate = 2'd2;
        sample();
        chk("busy_done_ramren", {31'd0, ramREN}, 32'd1);
        chk("busy_done_dwait", {30'd0, dwait}, 32'd2);
        chk("busy_done_dload0", dload[31:0], 32'h1234);
        tick();
        dREN = 2'b00; ramload = 32'h0;
        sample();
        chk("busy_after_dwait", {30'd0, dwait}, 32'd3);
        chk("dload_hold", dload[31:0], 32'h1234);

        // RAM ERROR retried for two cycles, CPU1 icache
        iREN = 2'b10; iaddr = 64'h0000_0300_0000_0040; ramstate = 2'd3; ramload = 32'hAB;
        tick();
        for (int e = 0; e < 2; e++) begin
            sample();
            chk("err_ramren", {31'd0, ramREN}, 32'd1);
            chk("err_ramaddr", ramaddr, 32'h300);
            chk("err_iwait", {30'd0, iwait}, 32'd3);
            tick();
        end
        ramstate = 2'd2;
        sample();
        chk("err_done_iwait", {30'd0, iwait}, 32'd1);
        chk("err_done_iload1", iload[63:32], 32'hAB);
        tick();
        iREN = 2'b00;

        // Both CPUs read continuously: CPU0, CPU1, CPU0
        dREN = 2'b11; daddr = 64'h0000_0020_0000_0010;
        tick();
        sample();
        chk("rr0_ramaddr", ramaddr, 32'h10);
        chk("rr0_dwait", {30'd0, dwait}, 32'd2);
        tick();
        sample();
        chk("rr_gap_ramren", {31'd0, ramREN}, 32'd0);
        chk("rr_gap_dwait", {30'd0, dwait}, 32'd3);
        tick();
        sample();
        chk("rr1_ramaddr", ramaddr, 32'h20);
        chk("rr1_dwait", {30'd0, dwait}, 32'd1);
        tick();
        tick();
        sample();
        chk("rr2_ramaddr", ramaddr, 32'h10);
        chk("rr2_dwait", {30'd0, dwait}, 32'd2);
        tick();
        dREN = 2'b00;

        // Request dropped mid-access: no wait release, enables drop next cycle
        dREN = 2'b01; daddr = 64'h44; ramstate = 2'd1;
        tick();
        sample();
        chk("drop_ramren", {31'd0, ramREN}, 32'd1);
        dREN = 2'b00; ramstate = 2'd2;
        #1;
        chk("drop_nowait", {30'd0, dwait}, 32'd3);
        tick();
        sample();
        chk("drop_ramren_off", {31'd0, ramREN}, 32'd0);

        // Reset in the middle of an access
        dREN = 2'b01; ramstate = 2'd1;
        tick();
        sample();
        chk("midrst_ramren", {31'd0, ramREN}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0; dREN = 2'b00;
        sample();
        chk("midrst_ramren_off", {31'd0, ramREN}, 32'd0);
        chk("midrst_dwait", {30'd0, dwait}, 32'd3);
        chk("midrst_dload0", dload[31:0], 32'd0);

        // Coherent dcache write from CPU0
        dWEN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01;
        daddr = 64'h100; dstore = 64'hCAFE; ramstate = 2'd1;
        tick();
`ifdef MEM_ARBITER_COHERENCE_EN
        sample();
        chk("snp_ramwen", {31'd0, ramWEN}, 32'd0);
        chk("snp_ramren", {31'd0, ramREN}, 32'd0);
        chk("snp_ccwait", {30'd0, ccwait}, 32'd2);
        chk("snp_ccinv", {30'd0, ccinv}, 32'd2);
        chk("snp_addr1", ccsnoopaddr[63:32], 32'h100);
        chk("snp_addr0", ccsnoopaddr[31:0], 32'd0);
        chk("snp_dwait", {30'd0, dwait}, 32'd3);
        tick();
        sample();
        chk("coh_ramwen", {31'd0, ramWEN}, 32'd1);
        chk("coh_ccwait", {30'd0, ccwait}, 32'd2);
        chk("coh_busy_dwait", {30'd0, dwait}, 32'd3);
        ramstate = 2'd2;
        #1;
        chk("coh_done_dwait", {30'd0, dwait}, 32'd2);
        chk("coh_done_ccinv", {30'd0, ccinv}, 32'd2);
        chk("coh_done_addr1", ccsnoopaddr[63:32], 32'h100);
        tick();
        dWEN = 2'b00;
        sample();
        chk("coh_clr_ccwait", {30'd0, ccwait}, 32'd0);
        chk("coh_clr_ccinv", {30'd0, ccinv}, 32'd0);
        chk("coh_clr_addr1", ccsnoopaddr[63:32], 32'd0);
        chk("coh_clr_ramwen", {31'd0, ramWEN}, 32'd0);
`else
        sample();
        chk("nocoh_ramwen", {31'd0, ramWEN}, 32'd1);
        chk("nocoh_ramaddr", ramaddr, 32'h100);
        chk("nocoh_ccwait", {30'd0, ccwait}, 32'd0);
        ramstate = 2'd2;
        #1;
        chk("nocoh_dwait", {30'd0, dwait}, 32'd2);
        chk("nocoh_snpaddr", ccsnoopaddr[63:32], 32'd0);
        tick();
        dWEN = 2'b00;
        sample();
        chk("nocoh_ramwen_off", {31'd0, ramWEN}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
